// File: rtl/lieat_exu_wbu_pkg.sv
// Shared widths and state encoding for the writeback stage.
package lieat_exu_wbu_pkg;

    // Default data/pc and register-index widths for this core.
    localparam int XLEN_DEF    = 32;
    localparam int REG_IDX_DEF = 5;

    // Halt state: retire normally until an ebreak retires, then stop for good.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } wbu_state_e;

endpackage

// File: rtl/lieat_exu_wbu_arb.sv
// Two-way arbiter between the com and lsu result streams, one-hot grants.
module lieat_exu_wbu_arb #(
    parameter int LSU_PRIO = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic com_req,
    input  logic lsu_req,
    input  logic xfer,
    output logic grant_com,
    output logic grant_lsu
);

    // Set when the last accepted transfer came from lsu; reset value favours lsu first.
    logic last_lsu;

    // Grant selection: fixed lsu priority, or round-robin on contention.
    always_comb begin
        grant_com = 1'b0;
        grant_lsu = 1'b0;
        if (LSU_PRIO != 0) begin
            if (lsu_req) begin
                grant_lsu = 1'b1;
            end else if (com_req) begin
                grant_com = 1'b1;
            end
        end else if (com_req && lsu_req) begin
            if (last_lsu) begin
                grant_com = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
        end else begin
            grant_com = com_req;
            grant_lsu = lsu_req;
        end
    end

    // Round-robin pointer moves only when a transfer actually happens.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_lsu <= 1'b0;
        end else if (xfer) begin
            last_lsu <= grant_lsu;
        end
    end

endmodule

// File: rtl/lieat_exu_wbu.sv
// Writeback stage: arbitrates com/lsu results onto the single register-file
// write port, releases scoreboard entries, emits the retire trace and halts
// on ebreak.
module lieat_exu_wbu
    import lieat_exu_wbu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int REG_IDX  = REG_IDX_DEF,
    parameter int LSU_PRIO = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               com_wb_valid,
    output logic               com_wb_ready,
    input  logic [XLEN-1:0]    com_wb_pc,
    input  logic               com_wb_wen,
    input  logic [REG_IDX-1:0] com_wb_rd,
    input  logic [XLEN-1:0]    com_wb_data,
    input  logic               com_wb_ebreak,
    input  logic               lsu_wb_valid,
    output logic               lsu_wb_ready,
    input  logic [XLEN-1:0]    lsu_wb_pc,
    input  logic               lsu_wb_wen,
    input  logic [REG_IDX-1:0] lsu_wb_rd,
    input  logic [XLEN-1:0]    lsu_wb_data,
    output logic               rf_wen,
    output logic [REG_IDX-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               sb_clr_en,
    output logic [REG_IDX-1:0] sb_clr_idx,
    output logic               commit_valid,
    output logic [XLEN-1:0]    commit_pc,
    output logic               halt
);

    // x0 is hardwired to zero: a write to it is neither performed nor tracked.
    function automatic logic rd_writes(input logic wen, input logic [REG_IDX-1:0] rd);
        return wen & (rd != '0);
    endfunction

    wbu_state_e state, state_nxt;

    logic grant_com, grant_lsu;
    logic com_acc, lsu_acc, xfer;

    logic [XLEN-1:0]    sel_pc;
    logic [XLEN-1:0]    sel_data;
    logic [REG_IDX-1:0] sel_rd;
    logic               sel_wen;

    logic               vld_p1;
    logic               rf_wen_p1;
    logic [REG_IDX-1:0] rf_waddr_p1;
    logic [XLEN-1:0]    rf_wdata_p1;
    logic               sb_clr_en_p1;
    logic [REG_IDX-1:0] sb_clr_idx_p1;
    logic [XLEN-1:0]    commit_pc_p1;

    lieat_exu_wbu_arb #(
        .LSU_PRIO (LSU_PRIO)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .com_req   (com_wb_valid),
        .lsu_req   (lsu_wb_valid),
        .xfer      (xfer),
        .grant_com (grant_com),
        .grant_lsu (grant_lsu)
    );

    assign com_wb_ready = grant_com & ~halt;
    assign lsu_wb_ready = grant_lsu & ~halt;
    assign com_acc      = com_wb_valid & com_wb_ready;
    assign lsu_acc      = lsu_wb_valid & lsu_wb_ready;
    assign xfer         = com_acc | lsu_acc;

    // Grant mux: pick the accepted source's retire fields.
    always_comb begin
        sel_pc   = com_wb_pc;
        sel_data = com_wb_data;
        sel_rd   = com_wb_rd;
        sel_wen  = com_wb_wen;
        if (lsu_acc) begin
            sel_pc   = lsu_wb_pc;
            sel_data = lsu_wb_data;
            sel_rd   = lsu_wb_rd;
            sel_wen  = lsu_wb_wen;
        end
    end

    // ---- stage p1: registered retire outputs; fields hold their last accepted value ----
    // Retire register: pulses for one cycle per accepted instruction, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            rf_wen_p1     <= 1'b0;
            sb_clr_en_p1  <= 1'b0;
            rf_waddr_p1   <= '0;
            rf_wdata_p1   <= '0;
            sb_clr_idx_p1 <= '0;
            commit_pc_p1  <= '0;
        end else begin
            vld_p1       <= xfer;
            rf_wen_p1    <= xfer & rd_writes(sel_wen, sel_rd);
            sb_clr_en_p1 <= xfer & rd_writes(sel_wen, sel_rd);
            if (xfer) begin
                rf_waddr_p1   <= sel_rd;
                rf_wdata_p1   <= sel_data;
                sb_clr_idx_p1 <= sel_rd;
                commit_pc_p1  <= sel_pc;
            end
        end
    end

    assign rf_wen       = rf_wen_p1;
    assign rf_waddr     = rf_waddr_p1;
    assign rf_wdata     = rf_wdata_p1;
    assign sb_clr_en    = sb_clr_en_p1;
    assign sb_clr_idx   = sb_clr_idx_p1;
    assign commit_valid = vld_p1;
    assign commit_pc    = commit_pc_p1;

    // Halt FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt FSM next state: an accepted ebreak stops retirement until reset.
    always_comb begin
        state_nxt = state;
        if (state == ST_RUN && com_acc && com_wb_ebreak) begin
            state_nxt = ST_HALT;
        end
    end

    // Halt FSM output decode.
    always_comb begin
        halt = (state == ST_HALT);
    end

endmodule

// File: tb/tb_lieat_exu_wbu.sv
// Directed testbench for lieat_exu_wbu: round-robin (dut0) and lsu-priority
// (dut1) instances share one stimulus stream.
module tb_lieat_exu_wbu;

    logic        clock = 1'b0;
    logic        reset;
    logic        com_wb_valid, com_wb_wen, com_wb_ebreak;
    logic [31:0] com_wb_pc, com_wb_data;
    logic [4:0]  com_wb_rd;
    logic        lsu_wb_valid, lsu_wb_wen;
    logic [31:0] lsu_wb_pc, lsu_wb_data;
    logic [4:0]  lsu_wb_rd;

    logic        com_rdy0, lsu_rdy0, rf_wen0, sb_en0, cv0, halt0;
    logic [4:0]  waddr0, sb_idx0;
    logic [31:0] wdata0, cpc0;
    logic        com_rdy1, lsu_rdy1, rf_wen1, sb_en1, cv1, halt1;
    logic [4:0]  waddr1, sb_idx1;
    logic [31:0] wdata1, cpc1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    lieat_exu_wbu #(.XLEN(32), .REG_IDX(5), .LSU_PRIO(0)) dut0 (
        .clock(clock), .reset(reset),
        .com_wb_valid(com_wb_valid), .com_wb_ready(com_rdy0), .com_wb_pc(com_wb_pc),
        .com_wb_wen(com_wb_wen), .com_wb_rd(com_wb_rd), .com_wb_data(com_wb_data),
        .com_wb_ebreak(com_wb_ebreak),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_rdy0), .lsu_wb_pc(lsu_wb_pc),
        .lsu_wb_wen(lsu_wb_wen), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .rf_wen(rf_wen0), .rf_waddr(waddr0), .rf_wdata(wdata0),
        .sb_clr_en(sb_en0), .sb_clr_idx(sb_idx0),
        .commit_valid(cv0), .commit_pc(cpc0), .halt(halt0)
    );

    lieat_exu_wbu #(.XLEN(32), .REG_IDX(5), .LSU_PRIO(1)) dut1 (
        .clock(clock), .reset(reset),
        .com_wb_valid(com_wb_valid), .com_wb_ready(com_rdy1), .com_wb_pc(com_wb_pc),
        .com_wb_wen(com_wb_wen), .com_wb_rd(com_wb_rd), .com_wb_data(com_wb_data),
        .com_wb_ebreak(com_wb_ebreak),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_rdy1), .lsu_wb_pc(lsu_wb_pc),
        .lsu_wb_wen(lsu_wb_wen), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .rf_wen(rf_wen1), .rf_waddr(waddr1), .rf_wdata(wdata1),
        .sb_clr_en(sb_en1), .sb_clr_idx(sb_idx1),
        .commit_valid(cv1), .commit_pc(cpc1), .halt(halt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_com(input logic v, input logic [31:0] pc, input logic wen,
                           input logic [4:0] rd, input logic [31:0] data, input logic ebrk);
        com_wb_valid = v; com_wb_pc = pc; com_wb_wen = wen;
        com_wb_rd = rd; com_wb_data = data; com_wb_ebreak = ebrk;
    endtask

    task automatic set_lsu(input logic v, input logic [31:0] pc, input logic wen,
                           input logic [4:0] rd, input logic [31:0] data);
        lsu_wb_valid = v; lsu_wb_pc = pc; lsu_wb_wen = wen;
        lsu_wb_rd = rd; lsu_wb_data = data;
    endtask

    initial begin
        reset = 1'b1;
        set_com(0, 0, 0, 0, 0, 0);
        set_lsu(0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_rf_wen", rf_wen0, 0);
        chk("rst_commit", cv0, 0);
        chk("rst_sb_en", sb_en0, 0);
        chk("rst_halt", halt0, 0);
        chk("rst_wdata", wdata0, 0);

        // 1: single com retire
        set_com(1, 32'h8000_0000, 1, 5'd5, 32'h1234, 0);
        #1;
        chk("t1_com_rdy", com_rdy0, 1);
        step();
        set_com(0, 0, 0, 0, 0, 0);
        chk("t1_rf_wen", rf_wen0, 1);
        chk("t1_waddr", waddr0, 5);
        chk("t1_wdata", wdata0, 32'h1234);
        chk("t1_sb_en", sb_en0, 1);
        chk("t1_sb_idx", sb_idx0, 5);
        chk("t1_commit", cv0, 1);
        chk("t1_cpc", cpc0, 32'h8000_0000);
        step();
        chk("t1_pulse_end", cv0, 0);

        // 2/3: contention for 4 cycles; dut0 alternates lsu,com; dut1 always lsu
        set_com(1, 32'h100, 1, 5'd6, 32'hc0, 0);
        set_lsu(1, 32'h200, 1, 5'd7, 32'h10);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_lsu_rdy", lsu_rdy0, (i % 2 == 0) ? 1 : 0);
            chk("t2_com_rdy", com_rdy0, (i % 2 == 0) ? 0 : 1);
            chk("t3_lsu_rdy", lsu_rdy1, 1);
            chk("t3_com_rdy", com_rdy1, 0);
            step();
            chk("t2_commit", cv0, 1);
            chk("t2_cpc", cpc0, (i % 2 == 0) ? 32'h200 : 32'h100);
            chk("t2_waddr", waddr0, (i % 2 == 0) ? 7 : 6);
            chk("t3_commit", cv1, 1);
            chk("t3_cpc", cpc1, 32'h200);
        end
        set_lsu(0, 0, 0, 0, 0);

        // Same rd retired back-to-back gives two release pulses
        set_com(1, 32'h300, 1, 5'd3, 32'h1, 0);
        step();
        set_com(1, 32'h304, 1, 5'd3, 32'h2, 0);
        chk("b2b_sb_en0", sb_en0, 1);
        chk("b2b_sb_idx0", sb_idx0, 3);
        step();
        set_com(0, 0, 0, 0, 0, 0);
        chk("b2b_sb_en1", sb_en0, 1);
        chk("b2b_sb_idx1", sb_idx0, 3);
        chk("b2b_wdata1", wdata0, 32'h2);

        // 4: lsu write to x0
        set_lsu(1, 32'h400, 1, 5'd0, 32'hdead);
        step();
        set_lsu(0, 0, 0, 0, 0);
        chk("t4_rf_wen", rf_wen0, 0);
        chk("t4_sb_en", sb_en0, 0);
        chk("t4_commit", cv0, 1);
        chk("t4_cpc", cpc0, 32'h400);

        // 5: ebreak with lsu pending (pointer now favours com)
        set_com(1, 32'h8000_0010, 0, 5'd0, 0, 1);
        set_lsu(1, 32'h500, 1, 5'd9, 32'h55);
        #1;
        chk("t5_com_rdy", com_rdy0, 1);
        chk("t5_lsu_rdy", lsu_rdy0, 0);
        step();
        com_wb_ebreak = 1'b0;
        chk("t5_commit", cv0, 1);
        chk("t5_cpc", cpc0, 32'h8000_0010);
        chk("t5_halt", halt0, 1);
        for (int i = 0; i < 12; i++) begin
            chk("t5_com_rdy_h", com_rdy0, 0);
            chk("t5_lsu_rdy_h", lsu_rdy0, 0);
            step();
            chk("t5_commit_h", cv0, 0);
            chk("t5_rf_wen_h", rf_wen0, 0);
            chk("t5_halt_h", halt0, 1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_halt_clr", halt0, 0);

        // 6: reset the cycle after an accept
        set_com(0, 0, 0, 0, 0, 0);
        set_lsu(1, 32'h600, 1, 5'd4, 32'h66);
        step();
        chk("t6_commit_pre", cv0, 1);
        reset = 1'b1;
        set_lsu(0, 0, 0, 0, 0);
        step();
        chk("t6_rf_wen", rf_wen0, 0);
        chk("t6_commit", cv0, 0);
        chk("t6_sb_en", sb_en0, 0);
        reset = 1'b0;
        set_com(1, 32'h700, 1, 5'd1, 32'h7, 0);
        set_lsu(1, 32'h704, 1, 5'd2, 32'h8);
        #1;
        chk("t6_ptr_lsu", lsu_rdy0, 1);
        chk("t6_ptr_com", com_rdy0, 0);
        step();
        set_com(0, 0, 0, 0, 0, 0);
        set_lsu(0, 0, 0, 0, 0);
        chk("t6_cpc", cpc0, 32'h704);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
